zwolf_i2c_target: RTL

//  I2C target (slave) port that lets an external host control the Zwolf CPU.

---
 rtl/zwolf_i2c_pkg.sv | 27 ++
 rtl/zwolf_i2c_sync.sv | 60 ++++++
 rtl/zwolf_i2c_target.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/zwolf_i2c_pkg.sv
// Shared definitions for the Zwolf I2C control port: FSM states, command codes,
// default target address and the command-recognition helper.
package zwolf_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_WAIT     = 3'd7
    } i2c_state_e;

    localparam logic [7:0] CMD_HALT  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'h02;
    localparam logic [7:0] CMD_EXEC  = 8'h03;
    localparam logic [7:0] CMD_DATA  = 8'h04;

    localparam logic [6:0] I2C_ADDR_RESET = 7'h0c;

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_HALT) || (b == CMD_RESET) || (b == CMD_EXEC) || (b == CMD_DATA);
    endfunction

endpackage

// File: rtl/zwolf_i2c_sync.sv
// Two-flop synchronizer plus persistence filter for one I2C pin. The filtered
// level only moves after GLITCH_LEN consecutive samples agree on the new value;
// rise/fall strobes are one clk wide and aligned with the filtered level change.
module zwolf_i2c_sync #(
    parameter int GLITCH_LEN = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [3:0] CNT_MAX = 4'(GLITCH_LEN - 1);

    logic       meta_q, sync_q;
    logic       filt_q, filt_d;
    logic       prev_q;
    logic [3:0] cnt_q, cnt_d;

    // Bring the asynchronous pin into the clk domain (idle bus level is high)
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_MAX) filt_d = sync_q;
            else                  cnt_d  = cnt_q + 4'd1;
        end
    end

    // Filter state and previous level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/zwolf_i2c_target.sv
// I2C target that lets an external host halt, restart and feed opcodes/operands
// to the Zwolf CPU, and read back the CPU's io_wdata byte.
module zwolf_i2c_target
    import zwolf_i2c_pkg::*;
#(
    parameter int GLITCH_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i2c_addr,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] io_rdata,
    input  logic [7:0] io_wdata,
    output logic       ext_halt,
    output logic       ext_reset,
    output logic       ext_execute,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    zwolf_i2c_sync #(.GLITCH_LEN(GLITCH_LEN)) u_scl_sync (
        .clk(clk), .reset(reset), .raw_i(scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    zwolf_i2c_sync #(.GLITCH_LEN(GLITCH_LEN)) u_sda_sync (
        .clk(clk), .reset(reset), .raw_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bitcnt_q;
    logic       done_q;       // 8th bit sampled; the ack slot starts at the next SCL fall
    logic       rw_q;
    logic       opnd_pend_q;  // EXEC/DATA seen, next byte is its operand
    logic       opnd_exec_q;  // pending operand belongs to EXEC
    logic       halt_q, rst_q, exec_q;
    logic [7:0] rdata_q;
    logic [7:0] shreg_q;

    logic       start_det, stop_det, last_bit, shifting;
    logic [7:0] rx_byte;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign last_bit  = scl_rise & (bitcnt_q == 3'd7);
    assign rx_byte   = {shreg_q[6:0], sda_lvl};
    assign shifting  = (state_q == ST_ADDR) || (state_q == ST_RX) || (state_q == ST_TX);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; START/STOP override everything, ack slots span fall to fall
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (last_bit && (rx_byte[7:1] != i2c_addr)) state_d = ST_WAIT;
                    else if (scl_fall && done_q)                state_d = ST_ADDR_ACK;
                end
                ST_ADDR_ACK: if (scl_fall) state_d = rw_q ? ST_TX : ST_RX;
                ST_RX: begin
                    if (last_bit && !opnd_pend_q && !is_known_cmd(rx_byte)) state_d = ST_WAIT;
                    else if (scl_fall && done_q)                            state_d = ST_RX_ACK;
                end
                ST_RX_ACK:   if (scl_fall) state_d = ST_RX;
                ST_TX:       if (scl_fall && done_q) state_d = ST_TX_ACK;
                ST_TX_ACK: begin
                    if (scl_rise && sda_lvl) state_d = ST_WAIT;
                    else if (scl_fall)       state_d = ST_TX;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs: drive ACK during ack slots, inverted data bit while transmitting
    always_comb begin
        sda_oe = 1'b0;
        busy   = 1'b0;
        case (state_q)
            ST_ADDR_ACK, ST_RX_ACK: begin
                sda_oe = 1'b1;
                busy   = 1'b1;
            end
            ST_TX: begin
                sda_oe = ~shreg_q[7];
                busy   = 1'b1;
            end
            ST_RX, ST_TX_ACK: busy = 1'b1;
            default: ;
        endcase
    end

    // Bit counter, command/operand tracking and one-clk action pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_q    <= '0;
            done_q      <= 1'b0;
            rw_q        <= 1'b0;
            opnd_pend_q <= 1'b0;
            opnd_exec_q <= 1'b0;
            halt_q      <= 1'b0;
            rst_q       <= 1'b0;
            exec_q      <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            halt_q <= 1'b0;
            rst_q  <= 1'b0;
            exec_q <= 1'b0;
            if (start_det || stop_det) begin
                bitcnt_q    <= '0;
                done_q      <= 1'b0;
                opnd_pend_q <= 1'b0;
            end else if (scl_rise && shifting) begin
                bitcnt_q <= bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    done_q <= 1'b1;
                    if (state_q == ST_ADDR) rw_q <= sda_lvl;
                    if (state_q == ST_RX) begin
                        if (opnd_pend_q) begin
                            rdata_q     <= rx_byte;
                            exec_q      <= opnd_exec_q;
                            opnd_pend_q <= 1'b0;
                        end else begin
                            case (rx_byte)
                                CMD_HALT:  halt_q <= 1'b1;
                                CMD_RESET: rst_q  <= 1'b1;
                                CMD_EXEC: begin
                                    opnd_pend_q <= 1'b1;
                                    opnd_exec_q <= 1'b1;
                                end
                                CMD_DATA: begin
                                    opnd_pend_q <= 1'b1;
                                    opnd_exec_q <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end else if (scl_fall) begin
                done_q <= 1'b0;
            end
        end
    end

    // Shift register: shift in on SCL rise, load/shift out on SCL fall
    always_ff @(posedge clk) begin
        if (scl_rise && ((state_q == ST_ADDR) || (state_q == ST_RX))) begin
            shreg_q <= rx_byte;
        end else if (scl_fall) begin
            if (((state_q == ST_ADDR_ACK) && rw_q) || (state_q == ST_TX_ACK))
                shreg_q <= io_wdata;
            else if ((state_q == ST_TX) && !done_q)
                shreg_q <= {shreg_q[6:0], 1'b0};
        end
    end

    assign io_rdata    = rdata_q;
    assign ext_halt    = halt_q;
    assign ext_reset   = rst_q;
    assign ext_execute = exec_q;

endmodule
